// File: rtl/draw_ball_render.sv
// Overlays a filled ball (or a ring when BALL_OUTLINE_EN is defined) on the VGA pixel stream.
// The centre is captured once per frame on the vblnk rising edge; all signals see a fixed 2-cycle pipeline.
module draw_ball_render #(
    parameter int          RADIUS     = 10,
    parameter logic [11:0] BALL_COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        frame_latched
);

    localparam logic [12:0] RAD13  = 13'(RADIUS);
    localparam logic [10:0] RAD_SQ = 11'(RADIUS * RADIUS);
`ifdef BALL_OUTLINE_EN
    localparam logic [10:0] INNER_SQ = 11'((RADIUS - 2) * (RADIUS - 2));
`endif

    logic        r_vblnkPrev;
    logic [11:0] r_cx;
    logic [11:0] r_cy;
    logic        r_posValid;
    logic        r_frameLatched;

    logic [4:0]  r_adx;
    logic [4:0]  r_ady;
    logic        r_inBox;
    logic [10:0] r_hcount1;
    logic [10:0] r_vcount1;
    logic        r_hsync1;
    logic        r_vsync1;
    logic        r_hblnk1;
    logic        r_vblnk1;
    logic [11:0] r_rgb1;

    logic               w_capture;
    logic signed [12:0] w_dx;
    logic signed [12:0] w_dy;
    logic [12:0]        w_absDx;
    logic [12:0]        w_absDy;
    logic               w_inBox;
    logic [10:0]        w_adx11;
    logic [10:0]        w_ady11;
    logic [10:0]        w_d2;
    logic               w_hit;

    assign w_capture = vblnk_in & ~r_vblnkPrev;

    // Zero-extending both operands keeps negative offsets negative so they can never wrap into a hit.
    assign w_dx    = $signed({2'b00, hcount_in}) - $signed({1'b0, r_cx});
    assign w_dy    = $signed({2'b00, vcount_in}) - $signed({1'b0, r_cy});
    assign w_absDx = w_dx[12] ? 13'(-w_dx) : 13'(w_dx);
    assign w_absDy = w_dy[12] ? 13'(-w_dy) : 13'(w_dy);
    assign w_inBox = r_posValid & ~hblnk_in & ~vblnk_in & (w_absDx <= RAD13) & (w_absDy <= RAD13);

    assign w_adx11 = {6'b0, r_adx};
    assign w_ady11 = {6'b0, r_ady};
    assign w_d2    = w_adx11 * w_adx11 + w_ady11 * w_ady11;
`ifdef BALL_OUTLINE_EN
    assign w_hit   = r_inBox & (w_d2 <= RAD_SQ) & (w_d2 > INNER_SQ);
`else
    assign w_hit   = r_inBox & (w_d2 <= RAD_SQ);
`endif

    // Centre latch: pixels on the capture edge still see the old centre.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_vblnkPrev    <= 1'b0;
            r_cx           <= 12'd0;
            r_cy           <= 12'd0;
            r_posValid     <= 1'b0;
            r_frameLatched <= 1'b0;
        end else begin
            r_vblnkPrev    <= vblnk_in;
            r_frameLatched <= w_capture;
            if (w_capture) begin
                r_cx       <= x_pos;
                r_cy       <= y_pos;
                r_posValid <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_adx     <= 5'd0;
            r_ady     <= 5'd0;
            r_inBox   <= 1'b0;
            r_hcount1 <= 11'd0;
            r_vcount1 <= 11'd0;
            r_hsync1  <= 1'b0;
            r_vsync1  <= 1'b0;
            r_hblnk1  <= 1'b0;
            r_vblnk1  <= 1'b0;
            r_rgb1    <= 12'd0;
        end else begin
            r_adx     <= w_inBox ? w_absDx[4:0] : 5'd0;
            r_ady     <= w_inBox ? w_absDy[4:0] : 5'd0;
            r_inBox   <= w_inBox;
            r_hcount1 <= hcount_in;
            r_vcount1 <= vcount_in;
            r_hsync1  <= hsync_in;
            r_vsync1  <= vsync_in;
            r_hblnk1  <= hblnk_in;
            r_vblnk1  <= vblnk_in;
            r_rgb1    <= rgb_in;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= r_hcount1;
            vcount_out <= r_vcount1;
            hsync_out  <= r_hsync1;
            vsync_out  <= r_vsync1;
            hblnk_out  <= r_hblnk1;
            vblnk_out  <= r_vblnk1;
            rgb_out    <= w_hit ? BALL_COLOR : r_rgb1;
        end
    end

    assign frame_latched = r_frameLatched;

endmodule

// File: tb/tb_draw_ball_render.sv
// Directed bench for draw_ball_render: reset, latency, frame latch, disc edges, clipping and mid-frame reset.
// Honours BALL_OUTLINE_EN for the few pixels whose colour depends on it.
module tb_draw_ball_render;

    logic        pclk = 1'b0;
    logic        reset;
    logic [11:0] x_pos, y_pos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        frame_latched;

    int errors = 0;
    int checks = 0;

    logic [11:0] histRgb [0:9];
    logic        histHs  [0:9];

`ifdef BALL_OUTLINE_EN
    localparam logic [11:0] EXP_C30    = 12'h000;
    localparam logic [11:0] EXP_CORNER = 12'h3C3;
`else
    localparam logic [11:0] EXP_C30    = 12'hFFF;
    localparam logic [11:0] EXP_CORNER = 12'hFFF;
`endif

    draw_ball_render dut (
        .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .frame_latched(frame_latched)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Hold one pixel for two rising edges so the outputs reflect it when this returns.
    task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                                 input logic hb);
        @(negedge pclk);
        hcount_in = h;
        vcount_in = v;
        rgb_in    = rgb;
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
    endtask

    task automatic latchCentre(input logic [11:0] x, input logic [11:0] y);
        @(negedge pclk);
        x_pos    = x;
        y_pos    = y;
        vblnk_in = 1'b0;
        hblnk_in = 1'b1;
        @(negedge pclk);
        vblnk_in = 1'b1;
        @(negedge pclk);
        checkOutput("frame_latched_pulse", {11'd0, frame_latched}, 12'd1);
        @(negedge pclk);
        checkOutput("frame_latched_single", {11'd0, frame_latched}, 12'd0);
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        x_pos = 12'd0; y_pos = 12'd0;
        hcount_in = 11'd0; vcount_in = 11'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'd0;

        // Reset held: random pixels and a vblnk pulse must not move any output.
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            rgb_in    = 12'($urandom);
            hcount_in = 11'(i + 100);
            hsync_in  = 1'b1;
            vblnk_in  = (i == 2);
        end
        @(negedge pclk);
        checkOutput("reset_rgb", rgb_out, 12'h000);
        checkOutput("reset_hcount", {1'b0, hcount_out}, 12'd0);
        checkOutput("reset_hsync", {11'd0, hsync_out}, 12'd0);
        checkOutput("reset_frame_latched", {11'd0, frame_latched}, 12'd0);
        vblnk_in = 1'b0;
        reset = 1'b1;

        // No capture yet: pure 2-cycle delay line.
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                checkOutput("delay_rgb", rgb_out, histRgb[i-2]);
                checkOutput("delay_hcount", {1'b0, hcount_out}, 12'(i - 2 + 200));
                checkOutput("delay_hsync", {11'd0, histHs[i-2]}, {11'd0, hsync_out});
                checkOutput("delay_no_latch", {11'd0, frame_latched}, 12'd0);
            end
            histRgb[i] = 12'($urandom);
            histHs[i]  = 1'($urandom);
            rgb_in     = histRgb[i];
            hsync_in   = histHs[i];
            hcount_in  = 11'(i + 200);
            vcount_in  = 11'd30;
        end

        // Ball at (30,30).
        latchCentre(12'd30, 12'd30);
        applyStimulus(11'd30, 11'd30, 12'h000, 1'b0); checkOutput("c30_centre", rgb_out, EXP_C30);
        applyStimulus(11'd40, 11'd30, 12'h000, 1'b0); checkOutput("c30_right_edge", rgb_out, 12'hFFF);
        applyStimulus(11'd41, 11'd30, 12'h000, 1'b0); checkOutput("c30_right_out", rgb_out, 12'h000);
        applyStimulus(11'd20, 11'd30, 12'h000, 1'b0); checkOutput("c30_left_edge", rgb_out, 12'hFFF);
        applyStimulus(11'd19, 11'd30, 12'h000, 1'b0); checkOutput("c30_left_out", rgb_out, 12'h000);
        applyStimulus(11'd38, 11'd36, 12'h000, 1'b0); checkOutput("c30_d2_100", rgb_out, 12'hFFF);
        applyStimulus(11'd38, 11'd37, 12'h000, 1'b0); checkOutput("c30_d2_113", rgb_out, 12'h000);
        applyStimulus(11'd30, 11'd21, 12'h000, 1'b0); checkOutput("c30_top", rgb_out, 12'hFFF);
        applyStimulus(11'd40, 11'd30, 12'h0A5, 1'b1);
        checkOutput("c30_hblank_rgb", rgb_out, 12'h0A5);
        checkOutput("c30_hblank_flag", {11'd0, hblnk_out}, 12'd1);
        checkOutput("c30_hcount_out", {1'b0, hcount_out}, 12'd40);

        // Mid-frame centre change is ignored until the next vblnk edge.
        @(negedge pclk);
        x_pos = 12'd500;
        applyStimulus(11'd40, 11'd30, 12'h000, 1'b0);  checkOutput("midframe_old", rgb_out, 12'hFFF);
        applyStimulus(11'd510, 11'd30, 12'h000, 1'b0); checkOutput("midframe_new_absent", rgb_out, 12'h000);
        latchCentre(12'd500, 12'd30);
        applyStimulus(11'd510, 11'd30, 12'h000, 1'b0); checkOutput("moved_new", rgb_out, 12'hFFF);
        applyStimulus(11'd40, 11'd30, 12'h000, 1'b0);  checkOutput("moved_old_gone", rgb_out, 12'h000);

        // Centre near the origin clips without wrap-around.
        latchCentre(12'd5, 12'd5);
        applyStimulus(11'd0, 11'd0, 12'h3C3, 1'b0);       checkOutput("clip_origin", rgb_out, EXP_CORNER);
        applyStimulus(11'd15, 11'd5, 12'h3C3, 1'b0);      checkOutput("clip_right_edge", rgb_out, 12'hFFF);
        applyStimulus(11'd16, 11'd5, 12'h3C3, 1'b0);      checkOutput("clip_right_out", rgb_out, 12'h3C3);
        applyStimulus(11'd1023, 11'd1023, 12'h3C3, 1'b0); checkOutput("clip_far_corner", rgb_out, 12'h3C3);

        // Reset in the middle of a ball pixel.
        latchCentre(12'd30, 12'd30);
        applyStimulus(11'd40, 11'd30, 12'h111, 1'b0); checkOutput("prereset_hit", rgb_out, 12'hFFF);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_rgb", rgb_out, 12'h000);
        checkOutput("midreset_hcount", {1'b0, hcount_out}, 12'd0);
        @(negedge pclk);
        reset = 1'b1;
        applyStimulus(11'd40, 11'd30, 12'h111, 1'b0); checkOutput("postreset_no_ball", rgb_out, 12'h111);
        latchCentre(12'd30, 12'd30);
        applyStimulus(11'd40, 11'd30, 12'h111, 1'b0); checkOutput("postreset_relatch", rgb_out, 12'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
